// File: rtl/ritc_align_pkg.sv
// Shared types and constants for the RITC automatic bitslip aligner.
package ritc_align_pkg;

   localparam int SLIP_W = 4;
   localparam int WORD_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      COMPARE,
      SLIP,
      SETTLE,
      NEXT,
      DONE
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ritc_align_word_capture.sv
// Selects the addressed bit's nibble, assembles the two-beat training word and
// registers its comparison against the pattern.
module ritc_align_word_capture
   import ritc_align_pkg::*;
#(
   parameter int NUM_NIB = 72,
   parameter int IDX_W   = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_NIB*4-1:0]   data,
   input  logic [IDX_W-1:0]       idx,
   input  logic                   valid,
   input  logic                   sync,
   input  logic                   flush,
   input  logic                   ack,
   input  logic [WORD_W-1:0]      pattern,
   output logic                   word_ok,
   output logic                   word_match
);

   logic [3:0] nib [NUM_NIB];
   logic [3:0] nibble;
   logic [3:0] hi;
   logic       armed;

   // NOTE: every element is written on every pass, so no latch is inferred.
   always_comb begin
      for (int i = 0; i < NUM_NIB; i++) nib[i] = data[i*4 +: 4];
      nibble = nib[idx];
   end

   // NOTE: sequential state uses non-blocking assignments only; when ack and a new
   // completion land on the same edge, the later assignment (the new word) wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi         <= '0;
         armed      <= 1'b0;
         word_ok    <= 1'b0;
         word_match <= 1'b0;
      end else if (flush) begin
         armed   <= 1'b0;
         word_ok <= 1'b0;
      end else begin
         if (ack) word_ok <= 1'b0;
         if (valid) begin
            if (sync) begin
               hi    <= nibble;
               armed <= 1'b1;
            end else if (armed) begin
               armed      <= 1'b0;
               word_ok    <= 1'b1;
               word_match <= ({hi, nibble} == pattern);
            end
         end
      end
   end

endmodule

// File: rtl/ritc_auto_bitslip_align.sv
// Hardware bitslip training aligner: walks every RITC input bit, slipping each until
// its training word matches. Optional per-bit slip-count file: RITC_ALIGN_SLIPCOUNT_EN.
module ritc_auto_bitslip_align
   import ritc_align_pkg::*;
#(
   parameter  int NUM_CH     = 6,
   parameter  int NUM_BIT    = 12,
   parameter  int MAX_SLIP   = 8,
   parameter  int SETTLE_CYC = 4,
   parameter  int MATCH_CNT  = 2,
   localparam int NUM_LANE   = NUM_CH * NUM_BIT,
   localparam int IDX_W      = idx_w(NUM_CH * NUM_BIT)
) (
   input  logic                    SYSCLK,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [WORD_W-1:0]       pattern_i,
   input  logic [NUM_LANE*4-1:0]   data_i,
   input  logic                    valid_i,
   input  logic                    sync_i,
   output logic [NUM_LANE-1:0]     bitslip_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    fail_o,
   output logic [NUM_LANE-1:0]     fail_mask_o,
   output logic [IDX_W-1:0]        cur_idx_o,
   input  logic [IDX_W-1:0]        slip_rd_i,
   output logic [SLIP_W-1:0]       slip_cnt_o
);

   localparam logic [SLIP_W-1:0]   MAX_SLIP_L  = SLIP_W'(MAX_SLIP);
   localparam logic [SLIP_W-1:0]   SETTLE_LAST = SLIP_W'(SETTLE_CYC - 1);
   localparam logic [2:0]          MATCH_LAST  = 3'(MATCH_CNT - 1);
   localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_LANE - 1);
   localparam logic [NUM_LANE-1:0] LANE_ONE    = NUM_LANE'(1);

   state_t              state;
   logic [WORD_W-1:0]   pattern;
   logic [SLIP_W-1:0]   slips;
   logic [SLIP_W-1:0]   settle_cnt;
   logic [2:0]          match_cnt;
   logic                word_ok;
   logic                word_match;
   logic                flush;
   logic                ack;

   // Partial words are discarded whenever the addressed bit or its alignment changes.
   assign flush = (state == SETTLE) || (state == NEXT) || (state == IDLE);
   assign ack   = (state == COMPARE);

   ritc_align_word_capture #(
      .NUM_NIB (NUM_LANE),
      .IDX_W   (IDX_W)
   ) u_capture (
      .clk        (SYSCLK),
      .rst        (rst_i),
      .data       (data_i),
      .idx        (cur_idx_o),
      .valid      (valid_i),
      .sync       (sync_i),
      .flush      (flush),
      .ack        (ack),
      .pattern    (pattern),
      .word_ok    (word_ok),
      .word_match (word_match)
   );

   always_ff @(posedge SYSCLK or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         pattern     <= '0;
         slips       <= '0;
         settle_cnt  <= '0;
         match_cnt   <= '0;
         cur_idx_o   <= '0;
         bitslip_o   <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         fail_o      <= 1'b0;
         fail_mask_o <= '0;
      end else begin
         bitslip_o <= '0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  pattern     <= pattern_i;
                  done_o      <= 1'b0;
                  fail_o      <= 1'b0;
                  fail_mask_o <= '0;
                  cur_idx_o   <= '0;
                  slips       <= '0;
                  match_cnt   <= '0;
                  busy_o      <= 1'b1;
                  state       <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (word_ok) state <= COMPARE;
            end
            COMPARE: begin
               if (word_match) begin
                  if (match_cnt == MATCH_LAST) begin
                     state <= NEXT;
                  end else begin
                     match_cnt <= match_cnt + 1'b1;
                     state     <= CAPTURE;
                  end
               end else begin
                  match_cnt <= '0;
                  if (slips < MAX_SLIP_L) begin
                     bitslip_o <= LANE_ONE << cur_idx_o;
                     state     <= SLIP;
                  end else begin
                     fail_mask_o[cur_idx_o] <= 1'b1;
                     state                  <= NEXT;
                  end
               end
            end
            SLIP: begin
               slips      <= (slips == '1) ? slips : slips + 1'b1;
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
               else settle_cnt <= settle_cnt + 1'b1;
            end
            NEXT: begin
               slips     <= '0;
               match_cnt <= '0;
               if (cur_idx_o == LAST_IDX) begin
                  state <= DONE;
               end else begin
                  cur_idx_o <= cur_idx_o + 1'b1;
                  state     <= CAPTURE;
               end
            end
            DONE: begin
               done_o <= 1'b1;
               fail_o <= |fail_mask_o;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RITC_ALIGN_SLIPCOUNT_EN
   logic [SLIP_W-1:0] slip_file [NUM_LANE];

   // NOTE: this small file is reset like ordinary flops because it must read 0
   // before the first pass and is bulk-cleared on every accepted start anyway.
   always_ff @(posedge SYSCLK or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_LANE; i++) slip_file[i] <= '0;
         slip_cnt_o <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            for (int i = 0; i < NUM_LANE; i++) slip_file[i] <= '0;
         end else if (state == NEXT) begin
            slip_file[cur_idx_o] <= slips;
         end
         slip_cnt_o <= (slip_rd_i <= LAST_IDX) ? slip_file[slip_rd_i] : '0;
      end
   end
`else
   logic unused_slip_rd;
   assign unused_slip_rd = ^slip_rd_i;
   assign slip_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_ritc_auto_bitslip_align.sv
// Directed bench: a per-bit training-stream model that rotates on bitslip drives the
// aligner through aligned, slipped, stuck, stalled and reset-aborted passes.
module tb_ritc_auto_bitslip_align;

   localparam int NL         = 72;
   localparam int IDX_W      = 7;
   localparam int SETTLE_CYC = 4;

   logic            SYSCLK;
   logic            rst_i;
   logic            start_i;
   logic [7:0]      pattern_i;
   logic [NL*4-1:0] data_i;
   logic            valid_i;
   logic            sync_i;
   logic [NL-1:0]   bitslip_o;
   logic            busy_o;
   logic            done_o;
   logic            fail_o;
   logic [NL-1:0]   fail_mask_o;
   logic [IDX_W-1:0] cur_idx_o;
   logic [IDX_W-1:0] slip_rd_i;
   logic [3:0]      slip_cnt_o;

   ritc_auto_bitslip_align #(
      .NUM_CH(6), .NUM_BIT(12), .MAX_SLIP(8), .SETTLE_CYC(SETTLE_CYC), .MATCH_CNT(2)
   ) dut (
      .SYSCLK      (SYSCLK),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .pattern_i   (pattern_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .sync_i      (sync_i),
      .bitslip_o   (bitslip_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .fail_o      (fail_o),
      .fail_mask_o (fail_mask_o),
      .cur_idx_o   (cur_idx_o),
      .slip_rd_i   (slip_rd_i),
      .slip_cnt_o  (slip_cnt_o)
   );

   initial begin
      SYSCLK = 1'b0;
      forever #5 SYSCLK = ~SYSCLK;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Training-stream model: each bit carries its word rotated left by off[i].
   logic [7:0] tb_pattern = 8'hB4;
   int         off [NL];
   bit         stuck [NL];
   int         pulses_on [NL];
   int         total_pulses;
   int         onehot_err;
   int         min_gap;
   int         last_pulse;
   int         cyc = 0;
   bit         stall_mode = 1'b0;
   bit         dbl_sync_req = 1'b0;
   bit         phase = 1'b0;

   function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
      return (w << n) | (w >> (8 - n));
   endfunction

   task automatic clear_counts();
      for (int i = 0; i < NL; i++) pulses_on[i] = 0;
      total_pulses = 0;
      onehot_err   = 0;
      min_gap      = 1000;
      last_pulse   = -1;
   endtask

   initial begin
      logic [NL*4-1:0] d;
      logic [7:0]      w;
      bit              v, dbl, hi_beat;
      int              n;
      valid_i = 1'b0;
      sync_i  = 1'b0;
      data_i  = '0;
      forever begin
         @(negedge SYSCLK);
         cyc++;
         n = 0;
         for (int i = 0; i < NL; i++) begin
            if (bitslip_o[i]) begin
               n++;
               pulses_on[i]++;
               total_pulses++;
               off[i] = (off[i] + 1) % 8;
            end
         end
         if (n > 1) onehot_err++;
         if (n > 0) begin
            if (last_pulse >= 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
         end
         v   = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         dbl = v && dbl_sync_req && phase;
         if (dbl) dbl_sync_req = 1'b0;
         hi_beat = !phase || dbl;
         for (int i = 0; i < NL; i++) begin
            w = stuck[i] ? 8'h00 : rotl8(tb_pattern, off[i]);
            d[i*4 +: 4] = v ? (hi_beat ? w[7:4] : w[3:0]) : 4'($urandom);
         end
         data_i  = d;
         valid_i = v;
         sync_i  = v ? hi_beat : 1'($urandom_range(0, 1));
         if (v && !dbl) phase = ~phase;
      end
   end

   task automatic run_pass(input string tag, input int budget, input bit mid_start, output int cycles);
      pattern_i = tb_pattern;
      start_i   = 1'b1;
      @(posedge SYSCLK); #2;
      start_i = 1'b0;
      cycles  = 1;
      while (!done_o && cycles < budget) begin
         @(posedge SYSCLK); #2;
         cycles++;
         if (mid_start) begin
            start_i   = (cycles == 50);
            pattern_i = (cycles == 50) ? 8'h00 : tb_pattern;
         end
      end
      start_i   = 1'b0;
      pattern_i = tb_pattern;
      check({tag, "_done"}, done_o, 1'b1);
      check({tag, "_busy"}, busy_o, 1'b0);
   endtask

   initial begin
      int cycles;
      bit seen;
      rst_i     = 1'b1;
      start_i   = 1'b0;
      pattern_i = 8'hB4;
      slip_rd_i = '0;
      for (int i = 0; i < NL; i++) begin
         off[i]   = 0;
         stuck[i] = 1'b0;
      end
      clear_counts();
      repeat (4) @(posedge SYSCLK);
      #2 rst_i = 1'b0;
      @(posedge SYSCLK); #2;

      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_fail", fail_o, 1'b0);
      check("rst_bitslip", bitslip_o, '0);
      check("rst_mask", fail_mask_o, '0);
      check("rst_idx", cur_idx_o, '0);
      check("rst_slipcnt", slip_cnt_o, '0);

      // 1: everything aligned
      clear_counts();
      run_pass("t1", 3000, 1'b0, cycles);
      check("t1_pulses", total_pulses, 0);
      check("t1_fail", fail_o, 1'b0);
      check("t1_mask", fail_mask_o, '0);
      check("t1_idx", cur_idx_o, 71);
      check("t1_len", (cycles >= 288 && cycles <= 864), 1'b1);

      // 2: bit 17 needs three slips
      off[17] = 5;
      clear_counts();
      run_pass("t2", 3000, 1'b0, cycles);
      check("t2_pulses17", pulses_on[17], 3);
      check("t2_pulses", total_pulses, 3);
      check("t2_onehot", onehot_err, 0);
      check("t2_gap", (min_gap >= SETTLE_CYC), 1'b1);
      check("t2_fail", fail_o, 1'b0);
      check("t2_off17", off[17], 0);

`ifdef RITC_ALIGN_SLIPCOUNT_EN
      // 6: slip-count readback
      slip_rd_i = 7'd17;
      @(posedge SYSCLK); #2;
      check("t6_cnt17", slip_cnt_o, 4'd3);
      slip_rd_i = 7'd72;
      @(posedge SYSCLK); #2;
      check("t6_cnt72", slip_cnt_o, 4'd0);
      slip_rd_i = 7'd16;
      @(posedge SYSCLK); #2;
      check("t6_cnt16", slip_cnt_o, 4'd0);
      slip_rd_i = '0;
`endif

      // 3: bit 5 stuck at zero
      stuck[5] = 1'b1;
      clear_counts();
      run_pass("t3", 4000, 1'b0, cycles);
      check("t3_pulses5", pulses_on[5], 8);
      check("t3_pulses", total_pulses, 8);
      check("t3_mask", fail_mask_o, 72'h1 << 5);
      check("t3_fail", fail_o, 1'b1);
      check("t3_idx", cur_idx_o, 71);
      stuck[5] = 1'b0;

      // 4: 50% valid gaps, one doubled sync, a start while busy, new pattern
      tb_pattern   = 8'h3C;
      stall_mode   = 1'b1;
      dbl_sync_req = 1'b1;
      clear_counts();
      run_pass("t4", 8000, 1'b1, cycles);
      check("t4_pulses", total_pulses, 0);
      check("t4_fail", fail_o, 1'b0);
      check("t4_mask", fail_mask_o, '0);
      check("t4_dbl_used", dbl_sync_req, 1'b0);
      stall_mode = 1'b0;
      tb_pattern = 8'hB4;

      // 5: reset while bit 17 is being slipped
      off[17] = 5;
      clear_counts();
      pattern_i = tb_pattern;
      start_i   = 1'b1;
      @(posedge SYSCLK); #2;
      start_i = 1'b0;
      seen    = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(posedge SYSCLK); #2;
         seen = (bitslip_o != '0);
      end
      check("t5_slip17", bitslip_o[17], 1'b1);
      rst_i = 1'b1;
      @(posedge SYSCLK); #2;
      check("t5_bitslip", bitslip_o, '0);
      check("t5_busy", busy_o, 1'b0);
      check("t5_done", done_o, 1'b0);
      check("t5_nopulse", total_pulses, 0);
      rst_i = 1'b0;
      @(posedge SYSCLK); #2;
      clear_counts();
      run_pass("t5", 3000, 1'b0, cycles);
      check("t5_pulses17", pulses_on[17], 3);
      check("t5_fail", fail_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
